// File: rtl/pipeline_control_arbiter_pkg.sv
// Shared LC-3b pipeline control types and helpers for the pipeline control arbiter.
// Provides the control word, requester slot names and the field-wise merge function.
package lc3b_types;

  typedef struct packed {
    logic active;
    logic exclusive;
    logic if_stall;
    logic id_stall;
    logic id_ex_stall;
    logic ex_stall;
    logic mem_stall;
    logic if_id_reset;
    logic id_ex_reset;
    logic ex_mem_reset;
    logic mem_wb_reset;
    logic force_sr1_load;
    logic force_sr2_load;
  } lc3b_pipeline_control_word;

  typedef enum logic [1:0] {
    REQ_BRANCH = 2'd0,
    REQ_HAZARD = 2'd1,
    REQ_ICACHE = 2'd2,
    REQ_DCACHE = 2'd3
  } lc3b_pipe_req_idx;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // Every field is a request flag, so merging is a plain bitwise OR.
  function automatic lc3b_pipeline_control_word lc3b_pipeline_control_or(
    input lc3b_pipeline_control_word a,
    input lc3b_pipeline_control_word b
  );
    lc3b_pipeline_control_word r;
    r = a | b;
    return r;
  endfunction

  function automatic logic lc3b_ctl_has_stall(input lc3b_pipeline_control_word w);
    return w.if_stall | w.id_stall | w.id_ex_stall | w.ex_stall | w.mem_stall;
  endfunction

  function automatic logic lc3b_ctl_has_reset(input lc3b_pipeline_control_word w);
    return w.if_id_reset | w.id_ex_reset | w.ex_mem_reset | w.mem_wb_reset;
  endfunction

endpackage

// File: rtl/pipeline_control_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping modulo N, returned as a one-hot grant.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         grant_o
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N)) begin
        sum = sum - (IDX_W+1)'(N);
      end
      idx = sum[IDX_W-1:0];
      if (!found && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipeline_control_arbiter.sv
// Merges per-requester pipeline control words into one word; exclusive requests are
// granted round-robin and locked to one owner. Optional stats: PIPE_ARB_STATS_EN.
module pipeline_control_arbiter
  import lc3b_types::*;
#(
  parameter int NUM_REQ = 4,
  parameter int STAT_W  = 32
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  lc3b_pipeline_control_word [NUM_REQ-1:0] req_i,
  output lc3b_pipeline_control_word               merged_o,
  output logic [NUM_REQ-1:0]                      excl_grant_o,
  output logic                                    locked_o,
  output logic [STAT_W-1:0]                       stall_cyc_o,
  output logic [STAT_W-1:0]                       flush_cyc_o,
  output logic [STAT_W-1:0]                       excl_cyc_o
);

  localparam int OWNER_W = $clog2(NUM_REQ);

  arb_state_e                state_q, state_d;
  logic [OWNER_W-1:0]        owner_q, owner_d;
  logic [OWNER_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [OWNER_W-1:0]        pick_idx;
  logic [NUM_REQ-1:0]        live;
  logic [NUM_REQ-1:0]        excl_live;
  logic [NUM_REQ-1:0]        pick_oh;
  logic [NUM_REQ-1:0]        grant;
  lc3b_pipeline_control_word merged;

  always_comb begin
    live      = '0;
    excl_live = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      live[i]      = req_i[i].active;
      excl_live[i] = req_i[i].active & req_i[i].exclusive;
    end
  end

  rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
    .req_i   (excl_live),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_oh)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx = OWNER_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    grant    = '0;
    merged   = '0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|excl_live) begin
          grant[pick_idx] = 1'b1;
          merged          = req_i[pick_idx];
          state_d         = ARB_LOCKED;
          owner_d         = pick_idx;
        end else begin
          for (int i = 0; i < NUM_REQ; i++) begin
            if (live[i]) begin
              merged = lc3b_pipeline_control_or(merged, req_i[i]);
            end
          end
        end
      end
      ARB_LOCKED: begin
        if (excl_live[owner_q]) begin
          grant[owner_q] = 1'b1;
          merged         = req_i[owner_q];
        end else begin
          // Release cycle: exclusive requesters wait one bubble before the next grant.
          for (int i = 0; i < NUM_REQ; i++) begin
            if (live[i] && !req_i[i].exclusive) begin
              merged = lc3b_pipeline_control_or(merged, req_i[i]);
            end
          end
          state_d  = ARB_IDLE;
          rr_ptr_d = (owner_q == OWNER_W'(NUM_REQ - 1)) ? '0 : owner_q + OWNER_W'(1);
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
    merged.exclusive = |grant;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Combinational outputs are forced quiet for the whole time reset is asserted.
  assign merged_o     = rst_n ? merged : '0;
  assign excl_grant_o = rst_n ? grant  : '0;
  assign locked_o     = (state_q == ARB_LOCKED);

`ifdef PIPE_ARB_STATS_EN
  logic [STAT_W-1:0] stall_cyc_q, stall_cyc_d;
  logic [STAT_W-1:0] flush_cyc_q, flush_cyc_d;
  logic [STAT_W-1:0] excl_cyc_q,  excl_cyc_d;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cyc_d = flush_cyc_q;
    excl_cyc_d  = excl_cyc_q;
    if (lc3b_ctl_has_stall(merged_o)) stall_cyc_d = sat_inc(stall_cyc_q);
    if (lc3b_ctl_has_reset(merged_o)) flush_cyc_d = sat_inc(flush_cyc_q);
    if (|excl_grant_o)                excl_cyc_d  = sat_inc(excl_cyc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cyc_q <= '0;
      flush_cyc_q <= '0;
      excl_cyc_q  <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cyc_q <= flush_cyc_d;
      excl_cyc_q  <= excl_cyc_d;
    end
  end

  assign stall_cyc_o = stall_cyc_q;
  assign flush_cyc_o = flush_cyc_q;
  assign excl_cyc_o  = excl_cyc_q;
`else
  assign stall_cyc_o = '0;
  assign flush_cyc_o = '0;
  assign excl_cyc_o  = '0;
`endif

endmodule

// File: tb/tb_pipeline_control_arbiter.sv
// Self-checking bench for pipeline_control_arbiter: directed scenarios plus
// randomized traffic checked against a cycle-level reference model.
module tb_pipeline_control_arbiter;
  import lc3b_types::*;

  localparam int N  = 4;
  localparam int SW = 32;
  localparam int WW = $bits(lc3b_pipeline_control_word);
`ifdef PIPE_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                                clk = 1'b0;
  logic                                rst_n;
  lc3b_pipeline_control_word [N-1:0]   req;
  lc3b_pipeline_control_word           merged_o;
  logic [N-1:0]                        excl_grant_o;
  logic                                locked_o;
  logic [SW-1:0]                       stall_cyc_o, flush_cyc_o, excl_cyc_o;

  int checks   = 0;
  int failures = 0;

  bit          m_locked;
  int          m_owner;
  int          m_rr;
  logic [31:0] m_stall, m_flush, m_excl;

  pipeline_control_arbiter #(.NUM_REQ(N), .STAT_W(SW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .merged_o     (merged_o),
    .excl_grant_o (excl_grant_o),
    .locked_o     (locked_o),
    .stall_cyc_o  (stall_cyc_o),
    .flush_cyc_o  (flush_cyc_o),
    .excl_cyc_o   (excl_cyc_o)
  );

  always #5 clk = ~clk;

  function automatic bit tb_any_stall(input lc3b_pipeline_control_word w);
    return (w.if_stall || w.id_stall || w.id_ex_stall || w.ex_stall || w.mem_stall);
  endfunction

  function automatic bit tb_any_reset(input lc3b_pipeline_control_word w);
    return (w.if_id_reset || w.id_ex_reset || w.ex_mem_reset || w.mem_wb_reset);
  endfunction

  task automatic model_reset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_rr     = 0;
    m_stall  = '0;
    m_flush  = '0;
    m_excl   = '0;
  endtask

  // Reference: decide this cycle's outputs and the next lock state from the rules.
  task automatic model_comb(output lc3b_pipeline_control_word m, output logic [N-1:0] g,
                            output bit nl, output int no, output int nr);
    int pick;
    m    = '0;
    g    = '0;
    nl   = m_locked;
    no   = m_owner;
    nr   = m_rr;
    pick = -1;
    if (!m_locked) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_rr + k) % N;
        if (pick < 0 && req[j].active && req[j].exclusive) pick = j;
      end
      if (pick >= 0) begin
        m       = req[pick];
        g[pick] = 1'b1;
        nl      = 1'b1;
        no      = pick;
      end else begin
        for (int i = 0; i < N; i++)
          if (req[i].active) m = lc3b_pipeline_control_word'(m | req[i]);
      end
    end else if (req[m_owner].active && req[m_owner].exclusive) begin
      m          = req[m_owner];
      g[m_owner] = 1'b1;
    end else begin
      for (int i = 0; i < N; i++)
        if (req[i].active && !req[i].exclusive) m = lc3b_pipeline_control_word'(m | req[i]);
      nl = 1'b0;
      nr = (m_owner + 1) % N;
    end
    m.exclusive = (g != '0);
  endtask

  // Called at a falling edge: compare against the model, then cross the rising edge.
  task automatic advance();
    lc3b_pipeline_control_word em;
    logic [N-1:0]              eg;
    bit                        nl;
    int                        no, nr;
    logic [31:0]               es, ef, ex;
    model_comb(em, eg, nl, no, nr);
    es = STATS ? m_stall : 32'd0;
    ef = STATS ? m_flush : 32'd0;
    ex = STATS ? m_excl  : 32'd0;
    checks++;
    if (merged_o !== em) begin
      failures++;
      $display("FAIL model_merged t=%0t got=%h exp=%h", $time, merged_o, em);
    end
    checks++;
    if (excl_grant_o !== eg) begin
      failures++;
      $display("FAIL model_grant t=%0t got=%b exp=%b", $time, excl_grant_o, eg);
    end
    checks++;
    if (locked_o !== m_locked) begin
      failures++;
      $display("FAIL model_locked t=%0t got=%b exp=%b", $time, locked_o, m_locked);
    end
    checks++;
    if (stall_cyc_o !== es || flush_cyc_o !== ef || excl_cyc_o !== ex) begin
      failures++;
      $display("FAIL model_stats t=%0t got=%0d/%0d/%0d exp=%0d/%0d/%0d", $time,
               stall_cyc_o, flush_cyc_o, excl_cyc_o, es, ef, ex);
    end
    @(posedge clk);
    m_locked = nl;
    m_owner  = no;
    m_rr     = nr;
    if (tb_any_stall(em) && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (tb_any_reset(em) && m_flush != 32'hFFFF_FFFF) m_flush++;
    if (eg != '0 && m_excl != 32'hFFFF_FFFF) m_excl++;
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    advance();
  endtask

  task automatic do_reset();
    req   = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    req = '0;
    for (int i = 0; i < N; i++) begin
      req[i].active   = 1'b1;
      req[i].if_stall = 1'b1;
      req[i].ex_stall = 1'b1;
    end
    req[1].exclusive = 1'b1;
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (merged_o !== '0 || excl_grant_o !== '0 || locked_o !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs got=%h/%b/%b exp=0/0/0", merged_o, excl_grant_o, locked_o);
      end
      checks++;
      if (stall_cyc_o !== '0 || flush_cyc_o !== '0 || excl_cyc_o !== '0) begin
        failures++;
        $display("FAIL reset_stats got=%0d/%0d/%0d exp=0", stall_cyc_o, flush_cyc_o, excl_cyc_o);
      end
    end
    req = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
  endtask

  task automatic test_merge();
    lc3b_pipeline_control_word exp_w;
    req = '0;
    req[0].active      = 1'b1;
    req[0].if_stall    = 1'b1;
    req[0].if_id_reset = 1'b1;
    req[1].active      = 1'b1;
    req[1].id_ex_stall = 1'b1;
    req[2].mem_stall   = 1'b1;
    req[2].ex_mem_reset = 1'b1;
    exp_w = '0;
    exp_w.active      = 1'b1;
    exp_w.if_stall    = 1'b1;
    exp_w.if_id_reset = 1'b1;
    exp_w.id_ex_stall = 1'b1;
    @(negedge clk);
    checks++;
    if (merged_o !== exp_w) begin
      failures++;
      $display("FAIL merge_word got=%h exp=%h", merged_o, exp_w);
    end
    checks++;
    if (excl_grant_o !== '0) begin
      failures++;
      $display("FAIL merge_grant got=%b exp=0", excl_grant_o);
    end
    advance();
    req = '0;
    step();
  endtask

  task automatic test_exclusive_grant();
    lc3b_pipeline_control_word exp_w;
    do_reset();
    req[2].active    = 1'b1;
    req[2].exclusive = 1'b1;
    req[2].mem_stall = 1'b1;
    req[1].active    = 1'b1;
    req[1].ex_stall  = 1'b1;
    exp_w = '0;
    exp_w.active    = 1'b1;
    exp_w.exclusive = 1'b1;
    exp_w.mem_stall = 1'b1;
    @(negedge clk);
    checks++;
    if (excl_grant_o !== 4'b0100 || merged_o !== exp_w) begin
      failures++;
      $display("FAIL excl_grant got=%b/%h exp=0100/%h", excl_grant_o, merged_o, exp_w);
    end
    advance();
    @(negedge clk);
    checks++;
    if (locked_o !== 1'b1) begin
      failures++;
      $display("FAIL excl_locked got=%b exp=1", locked_o);
    end
    advance();
    req = '0;
    repeat (2) step();
  endtask

  task automatic test_round_robin();
    int order [4] = '{1, 3, 1, 3};
    do_reset();
    for (int g = 0; g < 4; g++) begin
      int o;
      o = order[g];
      req = '0;
      req[1].active = 1'b1; req[1].exclusive = 1'b1; req[1].ex_stall = 1'b1;
      req[3].active = 1'b1; req[3].exclusive = 1'b1; req[3].id_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        checks++;
        if (excl_grant_o !== (4'b0001 << o)) begin
          failures++;
          $display("FAIL rr_grant round=%0d cyc=%0d got=%b exp_owner=%0d", g, c, excl_grant_o, o);
        end
        advance();
      end
      req[o].active = 1'b0;
      @(negedge clk);
      checks++;
      if (excl_grant_o !== '0 || merged_o !== '0) begin
        failures++;
        $display("FAIL rr_bubble round=%0d got=%b/%h exp=0/0", g, excl_grant_o, merged_o);
      end
      advance();
    end
    req = '0;
    repeat (2) step();
  endtask

  task automatic test_release_same_cycle();
    lc3b_pipeline_control_word exp_w;
    do_reset();
    req[3].active = 1'b1; req[3].exclusive = 1'b1; req[3].id_ex_stall = 1'b1;
    step();
    step();
    req[3].active = 1'b0;
    req[0].active = 1'b1; req[0].exclusive = 1'b1; req[0].id_ex_reset = 1'b1;
    req[1].active = 1'b1; req[1].ex_stall = 1'b1;
    exp_w = '0;
    exp_w.active   = 1'b1;
    exp_w.ex_stall = 1'b1;
    @(negedge clk);
    checks++;
    if (excl_grant_o !== '0 || merged_o !== exp_w) begin
      failures++;
      $display("FAIL release_bubble got=%b/%h exp=0000/%h", excl_grant_o, merged_o, exp_w);
    end
    advance();
    exp_w = '0;
    exp_w.active      = 1'b1;
    exp_w.exclusive   = 1'b1;
    exp_w.id_ex_reset = 1'b1;
    @(negedge clk);
    checks++;
    if (excl_grant_o !== 4'b0001 || merged_o !== exp_w) begin
      failures++;
      $display("FAIL release_next got=%b/%h exp=0001/%h", excl_grant_o, merged_o, exp_w);
    end
    advance();
    req = '0;
    repeat (2) step();
  endtask

  task automatic test_async_reset();
    do_reset();
    req[2].active = 1'b1; req[2].exclusive = 1'b1; req[2].mem_stall = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (merged_o !== '0 || excl_grant_o !== '0 || locked_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%h/%b/%b exp=0/0/0", merged_o, excl_grant_o, locked_o);
    end
    checks++;
    if (excl_cyc_o !== '0) begin
      failures++;
      $display("FAIL async_reset_excl_cyc got=%0d exp=0", excl_cyc_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    req[0].active = 1'b1; req[0].exclusive = 1'b1;
    @(negedge clk);
    checks++;
    if (excl_grant_o !== 4'b0001) begin
      failures++;
      $display("FAIL async_reset_regrant got=%b exp=0001", excl_grant_o);
    end
    advance();
    req = '0;
    repeat (2) step();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        logic [WW-1:0]             r;
        lc3b_pipeline_control_word w;
        r = WW'($urandom);
        w = r;
        w.active    = ($urandom_range(3) != 0);
        w.exclusive = ($urandom_range(2) == 0);
        if (m_locked && i == m_owner && $urandom_range(4) != 0) begin
          w.active    = 1'b1;
          w.exclusive = 1'b1;
        end
        req[i] = w;
      end
      step();
    end
    req = '0;
    step();
  endtask

  initial begin
    req   = '0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_merge();
    test_exclusive_grant();
    test_round_robin();
    test_release_same_cycle();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
